// File: rtl/periph_bridge_pkg.sv
// ----------------------------------------------------------------------------
// periph_bridge_pkg
//   Shared definitions for the peripheral bridge and the hazard unit:
//     - bridge_state_t          : bridge FSM state encoding (IDLE, REQ, DONE)
//     - DEFAULT_PERIPHERAL_BASE : lowest byte address of the peripheral window
//     - periph_offset()         : byte address -> 32-bit peripheral offset
// ----------------------------------------------------------------------------
package periph_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    localparam logic [63:0] DEFAULT_PERIPHERAL_BASE = 64'h2000_0000;

    // Offset inside the peripheral window; the upper 32 bits are discarded.
    function automatic logic [31:0] periph_offset(input logic [63:0] byte_addr,
                                                  input logic [63:0] base);
        logic [63:0] diff;
        diff = byte_addr - base;
        return diff[31:0];
    endfunction

endpackage

// File: rtl/periph_bridge_if.sv
// ----------------------------------------------------------------------------
// periph_bridge_if
//   Peripheral-side bus between the bridge (master) and a peripheral (slave).
//     p_req   : request, high for the whole transaction
//     p_we    : write enable, held with p_req
//     p_addr  : 32-bit offset into the peripheral window, held with p_req
//     p_wdata : store data, held with p_req
//     p_ack   : one-cycle completion pulse from the peripheral
//     p_rdata : read data, valid while p_ack is high
//     p_err   : one-cycle timeout pulse (only with PERIPH_TIMEOUT_EN)
//   Handshake: a transaction starts when p_req rises and ends on the first
//   rising edge where p_ack is sampled 1 while p_req is 1; p_we/p_addr/p_wdata
//   stay stable over that whole window. p_ack outside a request is ignored.
//   Optional feature macro: PERIPH_TIMEOUT_EN (adds p_err).
// ----------------------------------------------------------------------------
interface periph_bridge_if;
    logic        p_req;
    logic        p_we;
    logic [31:0] p_addr;
    logic [63:0] p_wdata;
    logic        p_ack;
    logic [63:0] p_rdata;
`ifdef PERIPH_TIMEOUT_EN
    logic        p_err;
`endif

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_ack, p_rdata
`ifdef PERIPH_TIMEOUT_EN
        , output p_err
`endif
    );

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_ack, p_rdata
`ifdef PERIPH_TIMEOUT_EN
        , input p_err
`endif
    );
endinterface

// File: rtl/periph_bridge.sv
// ----------------------------------------------------------------------------
// periph_bridge
//   Turns an EX-stage peripheral access (d_valid) into a single transaction
//   on the peripheral bus and reports completion back with d_ready.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     d_valid       : access request from the hazard unit (held until done)
//     EX_mem_write  : 1 = store, 0 = load
//     addr, wdata   : EX byte address and store data
//     stall         : global pipeline stall
//     d_ready       : access complete, rdata valid (combinational)
//     rdata         : load result
//     dbg_state     : current FSM state, for observation
//     bus           : peripheral bus, master side
//   Handshake (pipeline side): d_valid is held by the pipeline until it sees
//   d_ready; d_ready is high only in DONE while d_valid is still high. Once
//   DONE is entered the bus access is never re-issued, even if stall keeps
//   d_valid up for several more cycles.
//   Optional feature macro: PERIPH_TIMEOUT_EN (REQ wait counter + p_err).
// ----------------------------------------------------------------------------
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter logic [63:0] PERIPHERAL_BASE = DEFAULT_PERIPHERAL_BASE,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          d_valid,
    input  logic          EX_mem_write,
    input  logic [63:0]   addr,
    input  logic [63:0]   wdata,
    input  logic          stall,
    output logic          d_ready,
    output logic [63:0]   rdata,
    output bridge_state_t dbg_state,
    periph_bridge_if.master bus
);

    // A zero timeout would make the wait counter meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("periph_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    bridge_state_t state;

`ifdef PERIPH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Number of REQ cycles already spent without p_ack.
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.p_req   <= 1'b0;
            bus.p_we    <= 1'b0;
            bus.p_addr  <= '0;
            bus.p_wdata <= '0;
            rdata       <= '0;
`ifdef PERIPH_TIMEOUT_EN
            bus.p_err   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
`ifdef PERIPH_TIMEOUT_EN
            bus.p_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (d_valid) begin
                        bus.p_we    <= EX_mem_write;
                        bus.p_addr  <= periph_offset(addr, PERIPHERAL_BASE);
                        bus.p_wdata <= wdata;
                        bus.p_req   <= 1'b1;
                        state       <= REQ;
`ifdef PERIPH_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end

                REQ: begin
                    // p_ack wins over a timeout expiring on the same edge.
                    if (bus.p_ack) begin
                        if (!bus.p_we) begin
                            rdata <= bus.p_rdata;
                        end
                        bus.p_req <= 1'b0;
                        bus.p_we  <= 1'b0;
                        state     <= DONE;
                    end
`ifdef PERIPH_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        rdata     <= '1;
                        bus.p_err <= 1'b1;
                        bus.p_req <= 1'b0;
                        bus.p_we  <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    // Leave as soon as the pipeline moves on or the access was
                    // flushed; a stalled pipeline keeps us parked here.
                    if (!stall || !d_valid) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign d_ready   = (state == DONE) && d_valid;
    assign dbg_state = state;

endmodule
